// File: rtl/adc_ctrl_pkg.sv
// Shared types and constants for the ADC sequencer controller: FSM state
// encoding, the response-channel map and the sequencer CSR command words.
package adc_ctrl_pkg;

    // Number of averaged channels exported to the register bank.
    localparam int NUM_CH_DEF = 5;

    // Length of the channel map below; NUM_CH must not exceed it.
    localparam int MAP_LEN = 5;

    // Sequencer response channel number for each averaged output slot.
    localparam logic [4:0] CH_MAP [0:MAP_LEN-1] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd6};

    // Sequencer CSR command words (bit0 is the run bit).
    localparam logic [31:0] CSR_RUN  = 32'd1;
    localparam logic [31:0] CSR_STOP = 32'd0;

    // Sequencer control FSM states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START_WR  = 3'd1,
        ST_START_RD  = 3'd2,
        ST_START_CHK = 3'd3,
        ST_RUN       = 3'd4,
        ST_STOP_WR   = 3'd5
    } seq_state_t;

    // Command word for a run (1) or stop (0) write.
    function automatic logic [31:0] csr_cmd(input logic run);
        return run ? CSR_RUN : CSR_STOP;
    endfunction

endpackage

// File: rtl/adc_avg_accum.sv
// Per-channel sample accumulators with a sweep counter. After 2^AVG_LOG2
// complete sweeps the sums are divided (truncating shift) and published as
// {4'b0, avg[11:0]} words, with a one-cycle update pulse.
module adc_avg_accum
    import adc_ctrl_pkg::*;
#(
    parameter int NUM_CH   = NUM_CH_DEF,
    parameter int AVG_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic                  rsp_valid_i,
    input  logic [4:0]            rsp_channel_i,
    input  logic [11:0]           rsp_data_i,
    input  logic                  rsp_eop_i,
    output logic [16*NUM_CH-1:0]  ch_data_o,
    output logic                  data_update_o
);

    // 2^AVG_LOG2 samples of 12 bits each fit exactly in ACC_W bits.
    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int SW_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [SW_W-1:0] SWEEP_LAST = SW_W'((1 << AVG_LOG2) - 1);

    logic [SW_W-1:0] sweep_q, sweep_d;
    logic            upd_q, upd_d;
    logic            beat;
    logic            wrap;

    // Truncating divide by the sweep count, zero-extended to the bank word.
    function automatic logic [15:0] avg_trunc(input logic [ACC_W-1:0] s);
        return {4'b0000, 12'(s >> AVG_LOG2)};
    endfunction

    assign beat = en_i && rsp_valid_i;
    // The EOP beat that closes the last sweep of an averaging window.
    assign wrap = beat && rsp_eop_i && (sweep_q == SWEEP_LAST);

    // Sweep counter and update pulse next-state.
    always_comb begin
        sweep_d = sweep_q;
        upd_d   = 1'b0;
        if (clr_i) begin
            sweep_d = '0;
        end else if (wrap) begin
            sweep_d = '0;
            upd_d   = 1'b1;
        end else if (beat && rsp_eop_i) begin
            sweep_d = sweep_q + 1'b1;
        end
    end

    // Sweep counter and update pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sweep_q <= '0;
            upd_q   <= 1'b0;
        end else begin
            sweep_q <= sweep_d;
            upd_q   <= upd_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic             hit;
        logic [ACC_W-1:0] sum;
        logic [ACC_W-1:0] acc_q, acc_d;
        logic [15:0]      avg_q, avg_d;

        assign hit = rsp_valid_i && (rsp_channel_i == CH_MAP[g]);
        // Running sum including this cycle's sample, so the EOP beat counts.
        assign sum = acc_q + (hit ? ACC_W'(rsp_data_i) : ACC_W'(0));

        // Accumulate mapped samples; clear on leaving RUN or at window end.
        always_comb begin
            acc_d = acc_q;
            avg_d = avg_q;
            if (clr_i) begin
                acc_d = '0;
            end else if (wrap) begin
                acc_d = '0;
                avg_d = avg_trunc(sum);
            end else if (beat) begin
                acc_d = sum;
            end
        end

        // Accumulator is always cleared before RUN, so it needs no reset.
        always_ff @(posedge clk) begin
            acc_q <= acc_d;
        end

        // Published average holds its value until the next window completes.
        always_ff @(posedge clk) begin
            if (reset) begin
                avg_q <= '0;
            end else begin
                avg_q <= avg_d;
            end
        end

        assign ch_data_o[16*g +: 16] = avg_q;
    end

    assign data_update_o = upd_q;

endmodule

// File: rtl/adc_seq_ctrl.sv
// ADC sequencer controller: starts the sequencer with a CSR write and
// confirms the run bit by readback (retrying up to MAX_TRIES), stops it on
// request or when end-of-packet stops arriving, and averages the response
// stream through adc_avg_accum while running.
module adc_seq_ctrl
    import adc_ctrl_pkg::*;
#(
    parameter int NUM_CH         = NUM_CH_DEF,
    parameter int AVG_LOG2       = 2,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int MAX_TRIES      = 3
) (
    input  logic                  clk_core,
    input  logic                  reset,
    input  logic                  adc_enable,
    output logic                  csr_address,
    output logic                  csr_write,
    output logic [31:0]           csr_writedata,
    output logic                  csr_read,
    input  logic [31:0]           csr_readdata,
    input  logic                  rsp_valid,
    input  logic [4:0]            rsp_channel,
    input  logic [11:0]           rsp_data,
    input  logic                  rsp_eop,
    output logic [16*NUM_CH-1:0]  ch_data,
    output logic                  data_update,
    output logic                  running,
    output logic                  fault
);

    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    seq_state_t       state_q, state_d;
    logic [TRY_W-1:0] try_q, try_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic             fault_q, fault_d;
    logic             eop_beat;
    logic             wd_expire;
    logic             in_run;
    logic             unused_rd;

    // Only the run bit of the readback carries meaning.
    assign unused_rd = ^csr_readdata[31:1];

    assign eop_beat  = rsp_valid && rsp_eop;
    // An EOP in the expiry cycle rescues the run.
    assign wd_expire = (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) && !eop_beat;
    assign in_run    = (state_q == ST_RUN);

    // State, retry counter, watchdog and sticky fault registers.
    always_ff @(posedge clk_core) begin
        if (reset) begin
            state_q <= ST_IDLE;
            try_q   <= '0;
            wdog_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            try_q   <= try_d;
            wdog_q  <= wdog_d;
            fault_q <= fault_d;
        end
    end

    // Next-state logic: start handshake, retry, run supervision and stop.
    always_comb begin
        state_d = state_q;
        try_d   = try_q;
        wdog_d  = '0;
        fault_d = fault_q;
        unique case (state_q)
            ST_IDLE: begin
                if (adc_enable) begin
                    state_d = ST_START_WR;
                    try_d   = TRY_W'(1);
                end else begin
                    fault_d = 1'b0;
                end
            end
            ST_START_WR:  state_d = ST_START_RD;
            ST_START_RD:  state_d = ST_START_CHK;
            ST_START_CHK: begin
                if (csr_readdata[0]) begin
                    state_d = ST_RUN;
                end else if (try_q < TRY_W'(MAX_TRIES)) begin
                    state_d = ST_START_WR;
                    try_d   = try_q + 1'b1;
                end else begin
                    fault_d = 1'b1;
                    state_d = ST_STOP_WR;
                end
            end
            ST_RUN: begin
                wdog_d = eop_beat ? '0 : wdog_q + 1'b1;
                if (wd_expire) begin
                    fault_d = 1'b1;
                end
                if (!adc_enable || wd_expire) begin
                    state_d = ST_STOP_WR;
                end
            end
            ST_STOP_WR:   state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Moore output decode from the registered state.
    always_comb begin
        csr_write     = 1'b0;
        csr_writedata = CSR_STOP;
        csr_read      = 1'b0;
        running       = 1'b0;
        unique case (state_q)
            ST_START_WR: begin
                csr_write     = 1'b1;
                csr_writedata = csr_cmd(1'b1);
            end
            ST_STOP_WR: begin
                csr_write     = 1'b1;
                csr_writedata = csr_cmd(1'b0);
            end
            ST_START_RD:  csr_read = 1'b1;
            ST_RUN:       running  = 1'b1;
            default:      ;
        endcase
    end

    assign csr_address = 1'b0;
    assign fault       = fault_q;

    adc_avg_accum #(
        .NUM_CH   (NUM_CH),
        .AVG_LOG2 (AVG_LOG2)
    ) u_accum (
        .clk           (clk_core),
        .reset         (reset),
        .en_i          (in_run),
        .clr_i         (!in_run),
        .rsp_valid_i   (rsp_valid),
        .rsp_channel_i (rsp_channel),
        .rsp_data_i    (rsp_data),
        .rsp_eop_i     (rsp_eop),
        .ch_data_o     (ch_data),
        .data_update_o (data_update)
    );

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Bench for adc_seq_ctrl: directed start/stop/timeout sequences plus
// randomized sweeps checked against an averaging model.
module tb_adc_seq_ctrl;

    localparam int NUM_CH   = 5;
    localparam int AVG_LOG2 = 2;
    localparam int TMO      = 100;
    localparam int TRIES    = 3;

    logic                 clk_core = 1'b0;
    logic                 reset;
    logic                 adc_enable;
    logic                 csr_address;
    logic                 csr_write;
    logic [31:0]          csr_writedata;
    logic                 csr_read;
    logic [31:0]          csr_readdata;
    logic                 rsp_valid;
    logic [4:0]           rsp_channel;
    logic [11:0]          rsp_data;
    logic                 rsp_eop;
    logic [16*NUM_CH-1:0] ch_data;
    logic                 data_update;
    logic                 running;
    logic                 fault;

    int n_assert = 0;
    int n_fail   = 0;
    int wr1_cnt  = 0;
    int wr0_cnt  = 0;
    int rd_cnt   = 0;
    int upd_cnt  = 0;
    logic rb_bit;
    int   exp_sum [NUM_CH];
    logic [16*NUM_CH-1:0] last_exp;

    always #5 clk_core = ~clk_core;

    adc_seq_ctrl #(
        .NUM_CH         (NUM_CH),
        .AVG_LOG2       (AVG_LOG2),
        .TIMEOUT_CYCLES (TMO),
        .MAX_TRIES      (TRIES)
    ) dut (
        .clk_core      (clk_core),
        .reset         (reset),
        .adc_enable    (adc_enable),
        .csr_address   (csr_address),
        .csr_write     (csr_write),
        .csr_writedata (csr_writedata),
        .csr_read      (csr_read),
        .csr_readdata  (csr_readdata),
        .rsp_valid     (rsp_valid),
        .rsp_channel   (rsp_channel),
        .rsp_data      (rsp_data),
        .rsp_eop       (rsp_eop),
        .ch_data       (ch_data),
        .data_update   (data_update),
        .running       (running),
        .fault         (fault)
    );

    // Sequencer CSR model: readback valid one cycle after the read strobe;
    // other cycles carry the opposite run bit to expose mistimed sampling.
    always @(posedge clk_core) begin
        if (csr_read) csr_readdata <= {31'h0, rb_bit};
        else          csr_readdata <= {31'h12345678, ~rb_bit};
    end

    // CSR traffic and update pulse counters.
    always @(posedge clk_core) begin
        if (csr_write && csr_writedata == 32'd1) wr1_cnt <= wr1_cnt + 1;
        if (csr_write && csr_writedata == 32'd0) wr0_cnt <= wr0_cnt + 1;
        if (csr_read)    rd_cnt  <= rd_cnt + 1;
        if (data_update) upd_cnt <= upd_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=hang required=finish");
        $fatal(1, "simulation time limit");
    end

    task automatic tick();
        @(negedge clk_core);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Averaged output slot of a response channel, or -1 when unmapped.
    function automatic int ch_slot(input int ch);
        case (ch)
            1: return 0;
            2: return 1;
            3: return 2;
            4: return 3;
            6: return 4;
            default: return -1;
        endcase
    endfunction

    function automatic logic [16*NUM_CH-1:0] model_avg();
        logic [16*NUM_CH-1:0] e;
        for (int i = 0; i < NUM_CH; i++)
            e[16*i +: 16] = 16'(exp_sum[i] / (1 << AVG_LOG2));
        return e;
    endfunction

    task automatic beat(input int ch, input int data, input bit eop);
        rsp_valid   = 1'b1;
        rsp_channel = 5'(ch);
        rsp_data    = 12'(data);
        rsp_eop     = eop;
        tick();
        rsp_valid   = 1'b0;
        rsp_eop     = 1'b0;
    endtask

    // One sweep: random subset of channels (always incl. unmapped 5) in
    // random order, each at most once, the last beat carrying EOP.
    task automatic do_sweep();
        int cand [9];
        int chans [$];
        int j, t, d, s;
        cand = '{0, 1, 2, 3, 4, 5, 6, 7, 31};
        for (int k = 0; k < 9; k++)
            if (cand[k] == 5 || $urandom_range(0, 1) == 1) chans.push_back(cand[k]);
        for (int k = chans.size() - 1; k > 0; k--) begin
            j = $urandom_range(0, k);
            t = chans[k]; chans[k] = chans[j]; chans[j] = t;
        end
        for (int k = 0; k < chans.size(); k++) begin
            d = $urandom_range(0, 4095);
            s = ch_slot(chans[k]);
            if (s >= 0) exp_sum[s] += d;
            repeat ($urandom_range(0, 2)) tick();
            beat(chans[k], d, k == chans.size() - 1);
        end
    endtask

    task automatic avg_round(input string tag);
        int u0;
        for (int i = 0; i < NUM_CH; i++) exp_sum[i] = 0;
        u0 = upd_cnt;
        repeat (1 << AVG_LOG2) do_sweep();
        last_exp = model_avg();
        chk({tag, "_upd_pulse"}, data_update, 1);
        chk({tag, "_ch_data"}, ch_data, last_exp);
        tick();
        chk({tag, "_upd_count"}, upd_cnt - u0, 1);
        chk({tag, "_upd_low"}, data_update, 0);
    endtask

    initial begin
        int c_w1, c_w0, c_rd, n, cnt;
        bit exp_w [12];
        bit exp_wd[12];
        bit exp_r [12];
        bit exp_f [12];
        reset = 1'b1; adc_enable = 1'b0; rb_bit = 1'b1;
        rsp_valid = 1'b0; rsp_channel = '0; rsp_data = '0; rsp_eop = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_running", running, 0);
        chk("rst_fault", fault, 0);
        chk("rst_csr_write", csr_write, 0);
        chk("rst_csr_read", csr_read, 0);
        chk("rst_ch_data", ch_data, 0);
        chk("rst_update", data_update, 0);
        chk("rst_csr_address", csr_address, 0);
        reset = 1'b0;
        tick();

        // Enable with good readback: W1 at N+1, R at N+2, running at N+4
        adc_enable = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("en_k%0d_write", k), csr_write, k == 1);
            chk($sformatf("en_k%0d_read", k), csr_read, k == 2);
            chk($sformatf("en_k%0d_running", k), running, k == 4);
            if (k == 1) chk("en_writedata", csr_writedata, 1);
        end
        c_w1 = wr1_cnt; c_w0 = wr0_cnt; c_rd = rd_cnt;
        chk("en_single_write", c_w1, 1);
        chk("en_single_read", c_rd, 1);
        repeat (40) tick();
        chk("run_quiet_w1", wr1_cnt, c_w1);
        chk("run_quiet_w0", wr0_cnt, c_w0);
        chk("run_quiet_rd", rd_cnt, c_rd);
        chk("run_still", running, 1);

        // Directed averaging: ch1 100..400, ch6 0xFFF as EOP beat
        n = upd_cnt;
        for (int s = 0; s < 4; s++) begin
            beat(1, 100 * (s + 1), 1'b0);
            tick();
            beat(6, 12'hFFF, 1'b1);
            if (s < 3) chk($sformatf("dir_no_upd_s%0d", s), data_update, 0);
        end
        chk("dir_upd_pulse", data_update, 1);
        chk("dir_ch1", ch_data[15:0], 16'h00FA);
        chk("dir_ch6", ch_data[79:64], 16'h0FFF);
        chk("dir_all", ch_data, {16'h0FFF, 48'h0, 16'h00FA});
        tick();
        chk("dir_upd_count", upd_cnt - n, 1);

        // Random sweeps with unmapped channels interleaved
        for (int r = 0; r < 3; r++) avg_round($sformatf("rnd%0d", r));

        // Disable mid-window, then re-enable: fresh window only
        do_sweep();
        do_sweep();
        adc_enable = 1'b0;
        tick();
        chk("dis_stop_write", csr_write, 1);
        chk("dis_stop_data", csr_writedata, 0);
        chk("dis_running", running, 0);
        tick();
        chk("dis_held", ch_data, last_exp);
        tick();
        adc_enable = 1'b1;
        repeat (4) tick();
        chk("reen_running", running, 1);
        avg_round("fresh");

        // Readback stuck at 0: three W1/R pairs, W0 with fault, restart
        adc_enable = 1'b0;
        repeat (3) tick();
        rb_bit = 1'b0;
        adc_enable = 1'b1;
        exp_w  = '{1,0,0,1,0,0,1,0,0,1,0,1};
        exp_wd = '{1,0,0,1,0,0,1,0,0,0,0,1};
        exp_r  = '{0,1,0,0,1,0,0,1,0,0,0,0};
        exp_f  = '{0,0,0,0,0,0,0,0,0,1,1,1};
        for (int k = 0; k < 12; k++) begin
            tick();
            chk($sformatf("stuck_k%0d_write", k + 1), csr_write, exp_w[k]);
            chk($sformatf("stuck_k%0d_read", k + 1), csr_read, exp_r[k]);
            chk($sformatf("stuck_k%0d_fault", k + 1), fault, exp_f[k]);
            if (exp_w[k]) chk($sformatf("stuck_k%0d_wdata", k + 1), csr_writedata, exp_wd[k]);
        end
        adc_enable = 1'b0;
        n = 0;
        while (fault !== 1'b0 && n < 30) begin tick(); n++; end
        chk("stuck_fault_cleared", fault, 0);
        c_w1 = wr1_cnt; c_w0 = wr0_cnt;
        repeat (5) tick();
        chk("idle_quiet", (wr1_cnt - c_w1) + (wr0_cnt - c_w0), 0);

        // Watchdog: RUN lasts exactly TMO cycles without EOP
        rb_bit = 1'b1;
        adc_enable = 1'b1;
        repeat (4) tick();
        chk("wd_running", running, 1);
        chk("wd_fault_pre", fault, 0);
        cnt = 1;
        while (running === 1'b1 && cnt < 2 * TMO) begin
            tick();
            if (running === 1'b1) cnt++;
        end
        chk("wd_run_len", cnt, TMO);
        chk("wd_stop_write", csr_write, 1);
        chk("wd_stop_data", csr_writedata, 0);
        chk("wd_fault", fault, 1);
        tick();
        tick();
        chk("wd_restart_write", csr_write, 1);
        chk("wd_restart_data", csr_writedata, 1);
        repeat (3) tick();
        chk("wd_rerun", running, 1);
        chk("wd_fault_sticky", fault, 1);

        // EOP in the expiry cycle keeps the run alive
        repeat (TMO - 1) tick();
        beat(2, 12'h123, 1'b1);
        chk("wd_eop_wins_run", running, 1);
        chk("wd_eop_wins_nowrite", csr_write, 0);
        repeat (TMO - 1) tick();
        chk("wd_cleared_run", running, 1);

        // Drop enable: stop write, fault clears in IDLE
        adc_enable = 1'b0;
        tick();
        chk("off_stop_write", csr_write, 1);
        chk("off_fault_held", fault, 1);
        tick();
        tick();
        chk("off_fault_cleared", fault, 0);
        chk("off_running", running, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
